// File: rtl/alu_share_sched.sv
// Two-requester scheduler for the shared integer ALU: arbitrates, issues one op
// per IDLE->EXEC->RESP pass and holds the registered result until taken.
module alu_share_sched #(
    parameter int XLEN      = 32,
    parameter int CTRL_W    = 4,
    parameter int PRIO_MODE = 0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_flush,
    input  logic [1:0]          i_req_valid,
    output logic [1:0]          o_req_ready,
    input  logic [2*XLEN-1:0]   i_req_op1,
    input  logic [2*XLEN-1:0]   i_req_op2,
    input  logic [2*CTRL_W-1:0] i_req_ctrl,
    output logic [XLEN-1:0]     o_alu_op1,
    output logic [XLEN-1:0]     o_alu_op2,
    output logic [CTRL_W-1:0]   o_alu_ctrl,
    output logic                o_alu_stall,
    input  logic [XLEN-1:0]     i_alu_result,
    output logic [1:0]          o_rsp_valid,
    input  logic [1:0]          i_rsp_ready,
    output logic [XLEN-1:0]     o_rsp_data
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [XLEN-1:0]   op1;
        logic [XLEN-1:0]   op2;
        logic [CTRL_W-1:0] ctrl;
    } req_t;

    state_t          state, state_nxt;
    req_t            req_sel, req_q;
    logic            gnt, gnt_q, last_grant;
    logic            accept;
    logic [1:0]      rsp_valid_q;
    logic [XLEN-1:0] rsp_data_q;

    // last_grant names the requester served most recently; it loses a tie
    always_comb begin
        gnt = 1'b0;
        if (PRIO_MODE != 0)
            gnt = !i_req_valid[0];
        else if (&i_req_valid)
            gnt = ~last_grant;
        else
            gnt = i_req_valid[1];
    end

    assign req_sel = gnt ? '{op1: i_req_op1[XLEN +: XLEN], op2: i_req_op2[XLEN +: XLEN],
                             ctrl: i_req_ctrl[CTRL_W +: CTRL_W]}
                         : '{op1: i_req_op1[0 +: XLEN], op2: i_req_op2[0 +: XLEN],
                             ctrl: i_req_ctrl[0 +: CTRL_W]};

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: if (!i_flush && (|i_req_valid)) begin
                accept    = 1'b1;
                state_nxt = EXEC;
            end
            EXEC: state_nxt = RESP;
            RESP: if (i_rsp_ready[gnt_q]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (i_flush) state_nxt = IDLE;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            req_q       <= '0;
            gnt_q       <= 1'b0;
            last_grant  <= 1'b1;
            rsp_valid_q <= 2'b00;
            rsp_data_q  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                req_q      <= req_sel;
                gnt_q      <= gnt;
                last_grant <= gnt;
            end
            // flush drops the in-flight result even if the requester is taking it
            if (i_flush)
                rsp_valid_q <= 2'b00;
            else if (state == EXEC) begin
                rsp_valid_q <= gnt_q ? 2'b10 : 2'b01;
                rsp_data_q  <= i_alu_result;
            end else if (state == RESP && i_rsp_ready[gnt_q])
                rsp_valid_q <= 2'b00;
        end
    end

    assign o_req_ready = accept ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    assign o_alu_op1   = req_q.op1;
    assign o_alu_op2   = req_q.op2;
    assign o_alu_ctrl  = req_q.ctrl;
    assign o_alu_stall = (state != EXEC);
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_alu_share_sched.sv
// Directed bench for alu_share_sched: vector table for arbitration/data plus
// hand sequences for backpressure, flush, async reset and fixed priority.
module tb_alu_share_sched;

    localparam int XLEN = 32;
    localparam int CW   = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush;
    logic [1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
    logic [63:0]     req_op1, req_op2;
    logic [7:0]      req_ctrl;
    logic [31:0]     alu_op1, alu_op2, alu_result, rsp_data;
    logic [3:0]      alu_ctrl;
    logic            alu_stall;

    logic            p_flush;
    logic [1:0]      p_req_valid, p_req_ready, p_rsp_valid, p_rsp_ready;
    logic [63:0]     p_req_op1, p_req_op2;
    logic [7:0]      p_req_ctrl;
    logic [31:0]     p_alu_op1, p_alu_op2, p_alu_result, p_rsp_data;
    logic [3:0]      p_alu_ctrl;
    logic            p_alu_stall;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // reference ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLTU
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] c);
        case (c)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return {31'b0, a < b};
            default: return 32'h0;
        endcase
    endfunction

    assign alu_result   = alu_f(alu_op1, alu_op2, alu_ctrl);
    assign p_alu_result = alu_f(p_alu_op1, p_alu_op2, p_alu_ctrl);

    alu_share_sched #(.XLEN(XLEN), .CTRL_W(CW), .PRIO_MODE(0)) u_rr (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_op1(req_op1), .i_req_op2(req_op2), .i_req_ctrl(req_ctrl),
        .o_alu_op1(alu_op1), .o_alu_op2(alu_op2), .o_alu_ctrl(alu_ctrl),
        .o_alu_stall(alu_stall), .i_alu_result(alu_result),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data)
    );

    alu_share_sched #(.XLEN(XLEN), .CTRL_W(CW), .PRIO_MODE(1)) u_prio (
        .i_clk(clk), .i_rst(rst), .i_flush(p_flush),
        .i_req_valid(p_req_valid), .o_req_ready(p_req_ready),
        .i_req_op1(p_req_op1), .i_req_op2(p_req_op2), .i_req_ctrl(p_req_ctrl),
        .o_alu_op1(p_alu_op1), .o_alu_op2(p_alu_op2), .o_alu_ctrl(p_alu_ctrl),
        .o_alu_stall(p_alu_stall), .i_alu_result(p_alu_result),
        .o_rsp_valid(p_rsp_valid), .i_rsp_ready(p_rsp_ready), .o_rsp_data(p_rsp_data)
    );

    typedef struct {
        logic [1:0]  v;
        logic [31:0] a0, b0;
        logic [3:0]  c0;
        logic [31:0] a1, b1;
        logic [3:0]  c1;
        int          g;
        logic [31:0] d;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] b0,
                           input logic [3:0] c0, input logic [31:0] a1, input logic [31:0] b1,
                           input logic [3:0] c1);
        req_valid = v;
        req_op1   = {a1, a0};
        req_op2   = {b1, b0};
        req_ctrl  = {c1, c0};
    endtask

    task automatic set_preq(input logic [1:0] v);
        p_req_valid = v;
        p_req_op1   = {32'hF0, 32'd10};
        p_req_op2   = {32'h0F, 32'd3};
        p_req_ctrl  = {4'd4, 4'd1};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{2'b11, 32'd10, 32'd3, 4'd1, 32'hF0, 32'h0F, 4'd4, 0, 32'd7};
        tbl[1] = '{2'b11, 32'd10, 32'd3, 4'd1, 32'hF0, 32'h0F, 4'd4, 1, 32'hFF};
        tbl[2] = '{2'b11, 32'd10, 32'd3, 4'd1, 32'hF0, 32'h0F, 4'd4, 0, 32'd7};
        tbl[3] = '{2'b11, 32'd10, 32'd3, 4'd1, 32'hF0, 32'h0F, 4'd4, 1, 32'hFF};
        tbl[4] = '{2'b01, 32'd10, 32'd3, 4'd1, 32'h0, 32'h0, 4'd0, 0, 32'd7};
        tbl[5] = '{2'b10, 32'h0, 32'h0, 4'd0, 32'h30, 32'h03, 4'd3, 1, 32'h33};
        tbl[6] = '{2'b10, 32'h0, 32'h0, 4'd0, 32'd2, 32'd1, 4'd5, 1, 32'd0};
        tbl[7] = '{2'b11, 32'hFFFF_FFFF, 32'd1, 4'd0, 32'hFF, 32'h0F, 4'd2, 0, 32'd0};
        tbl[8] = '{2'b11, 32'hFFFF_FFFF, 32'd1, 4'd0, 32'hFF, 32'h0F, 4'd2, 1, 32'h0F};

        flush = 1'b0; rsp_ready = 2'b00;
        set_req(2'b00, 0, 0, 0, 0, 0, 0);
        p_flush = 1'b0; p_rsp_ready = 2'b00;
        set_preq(2'b00);

        // reset state
        @(negedge clk);
        chk("rst_stall", {31'b0, alu_stall}, 32'd1);
        chk("rst_rsp_valid", {30'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_alu_op1", alu_op1, 32'd0);
        chk("rst_alu_ctrl", {28'b0, alu_ctrl}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // single op (T1 style) then table-driven arbitration/data
        @(negedge clk);
        set_req(2'b01, 32'd5, 32'd7, 4'd0, 0, 0, 0);
        rsp_ready = 2'b11;
        #1 chk("t1_ready", {30'b0, req_ready}, 32'h1);
        chk("t1_stall_c0", {31'b0, alu_stall}, 32'd1);
        @(negedge clk);
        set_req(2'b00, 0, 0, 0, 0, 0, 0);
        #1 chk("t1_stall_c1", {31'b0, alu_stall}, 32'd0);
        chk("t1_valid_c1", {30'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("t1_valid_c2", {30'b0, rsp_valid}, 32'h1);
        chk("t1_data", rsp_data, 32'd12);
        chk("t1_stall_c2", {31'b0, alu_stall}, 32'd1);

        // restart from reset so the both-valid run starts with req0 winning
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            set_req(tbl[i].v, tbl[i].a0, tbl[i].b0, tbl[i].c0, tbl[i].a1, tbl[i].b1, tbl[i].c1);
            rsp_ready = 2'b11;
            #1 chk($sformatf("v%0d_grant", i), {30'b0, req_ready},
                   (tbl[i].g == 1) ? 32'h2 : 32'h1);
            chk($sformatf("v%0d_idle_stall", i), {31'b0, alu_stall}, 32'd1);
            @(negedge clk);
            chk($sformatf("v%0d_exec_stall", i), {31'b0, alu_stall}, 32'd0);
            chk($sformatf("v%0d_exec_ready", i), {30'b0, req_ready}, 32'd0);
            chk($sformatf("v%0d_exec_op1", i), alu_op1, (tbl[i].g == 1) ? tbl[i].a1 : tbl[i].a0);
            chk($sformatf("v%0d_exec_ctrl", i), {28'b0, alu_ctrl},
                {28'b0, (tbl[i].g == 1) ? tbl[i].c1 : tbl[i].c0});
            @(negedge clk);
            chk($sformatf("v%0d_rsp_valid", i), {30'b0, rsp_valid},
                (tbl[i].g == 1) ? 32'h2 : 32'h1);
            chk($sformatf("v%0d_rsp_data", i), rsp_data, tbl[i].d);
        end

        // T3: req1 SLTU held by backpressure, req0 waits, wrong-bit ready ignored
        @(negedge clk);
        set_req(2'b10, 0, 0, 0, 32'd1, 32'd2, 4'd5);
        rsp_ready = 2'b00;
        #1 chk("t3_ready1", {30'b0, req_ready}, 32'h2);
        @(negedge clk);
        set_req(2'b11, 32'd5, 32'd7, 4'd0, 32'd1, 32'd2, 4'd5);
        #1 chk("t3_exec_ready", {30'b0, req_ready}, 32'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            rsp_ready = 2'b01;
            #1 chk($sformatf("t3_hold_valid%0d", k), {30'b0, rsp_valid}, 32'h2);
            chk($sformatf("t3_hold_data%0d", k), rsp_data, 32'd1);
            chk($sformatf("t3_hold_ready%0d", k), {30'b0, req_ready}, 32'h0);
        end
        @(negedge clk);
        rsp_ready = 2'b10;
        #1 chk("t3_release_valid", {30'b0, rsp_valid}, 32'h2);
        chk("t3_release_ready", {30'b0, req_ready}, 32'h0);
        @(negedge clk);
        rsp_ready = 2'b11;
        #1 chk("t3_after_valid", {30'b0, rsp_valid}, 32'h0);
        chk("t3_req0_ready", {30'b0, req_ready}, 32'h1);
        @(negedge clk);
        set_req(2'b10, 0, 0, 0, 32'd1, 32'd2, 4'd5);
        @(negedge clk);
        chk("t3_req0_data", rsp_data, 32'd12);
        chk("t3_req0_valid", {30'b0, rsp_valid}, 32'h1);
        @(negedge clk);
        #1 chk("t3_req1_again", {30'b0, req_ready}, 32'h2);
        @(negedge clk);
        set_req(2'b00, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t3_req1_data", rsp_data, 32'd1);

        // T4: flush in EXEC, then normal op, then flush blocks accept in IDLE
        @(negedge clk);
        set_req(2'b01, 32'd1, 32'd1, 4'd0, 0, 0, 0);
        #1 chk("t4_ready", {30'b0, req_ready}, 32'h1);
        @(negedge clk);
        flush = 1'b1;
        set_req(2'b00, 0, 0, 0, 0, 0, 0);
        #1 chk("t4_exec_stall", {31'b0, alu_stall}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1 chk("t4_flush_valid", {30'b0, rsp_valid}, 32'h0);
        chk("t4_flush_stall", {31'b0, alu_stall}, 32'd1);
        set_req(2'b01, 32'hFF, 32'h0F, 4'd2, 0, 0, 0);
        #1 chk("t4_idle_ready", {30'b0, req_ready}, 32'h1);
        @(negedge clk);
        set_req(2'b00, 0, 0, 0, 0, 0, 0);
        #1 chk("t4_exec2_stall", {31'b0, alu_stall}, 32'd0);
        @(negedge clk);
        chk("t4_and_valid", {30'b0, rsp_valid}, 32'h1);
        chk("t4_and_data", rsp_data, 32'h0F);
        @(negedge clk);
        flush = 1'b1;
        set_req(2'b01, 32'd2, 32'd3, 4'd0, 0, 0, 0);
        #1 chk("t4_flush_idle_ready", {30'b0, req_ready}, 32'h0);
        @(negedge clk);
        flush = 1'b0;
        #1 chk("t4_post_flush_ready", {30'b0, req_ready}, 32'h1);
        @(negedge clk);
        set_req(2'b00, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t4_add_data", rsp_data, 32'd5);

        // T5: async reset during RESP
        @(negedge clk);
        set_req(2'b01, 32'd5, 32'd7, 4'd0, 0, 0, 0);
        rsp_ready = 2'b00;
        #1 chk("t5_ready", {30'b0, req_ready}, 32'h1);
        @(negedge clk);
        set_req(2'b00, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t5_resp_valid", {30'b0, rsp_valid}, 32'h1);
        #2 rst = 1'b1;
        #1 chk("t5_rst_valid", {30'b0, rsp_valid}, 32'h0);
        chk("t5_rst_stall", {31'b0, alu_stall}, 32'd1);
        chk("t5_rst_data", rsp_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        set_req(2'b11, 32'd5, 32'd7, 4'd0, 32'hF0, 32'h0F, 4'd4);
        rsp_ready = 2'b11;
        #1 chk("t5_first_grant", {30'b0, req_ready}, 32'h1);
        @(negedge clk);
        set_req(2'b10, 0, 0, 0, 32'hF0, 32'h0F, 4'd4);
        @(negedge clk);
        chk("t5_data0", rsp_data, 32'd12);
        @(negedge clk);
        #1 chk("t5_second_grant", {30'b0, req_ready}, 32'h2);
        @(negedge clk);
        set_req(2'b00, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t5_data1", rsp_data, 32'hFF);

        // T6: fixed priority instance
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            set_preq(2'b11);
            p_rsp_ready = 2'b11;
            #1 chk($sformatf("t6_grant%0d", k), {30'b0, p_req_ready}, 32'h1);
            @(negedge clk);
            @(negedge clk);
            chk($sformatf("t6_valid%0d", k), {30'b0, p_rsp_valid}, 32'h1);
            chk($sformatf("t6_data%0d", k), p_rsp_data, 32'd7);
        end
        @(negedge clk);
        set_preq(2'b10);
        #1 chk("t6_req1_grant", {30'b0, p_req_ready}, 32'h2);
        @(negedge clk);
        set_preq(2'b00);
        @(negedge clk);
        chk("t6_req1_valid", {30'b0, p_rsp_valid}, 32'h2);
        chk("t6_req1_data", p_rsp_data, 32'hFF);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
